gpu_cmd_arbiter: RTL and testbench
==================================

# gpu_cmd_arbiter

Sequencer and arbiter that drives the GPU's 16-bit `cpuline` command bus on behalf of two requesters: port 0, the CPU, and port 1, the boot/debug console. It holds a shadow of the GPU's two-word cmd/param phase so that every opcode word lands in the GPU's "command" slot. It serialises requests into CMD, PARAM and EXEC slots, and it filters out opcodes the GPU cannot execute. It sits between the CPU bus glue and `GPU.cpuline`.

## Interface
- `EXEC_GAP`, default 1: number of zero-word cycles after PARAM before the next CMD may issue; minimum 1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `req0_valid`  in  1  port 0 has a command pending.
- `req0_cmd`  in  16  port 0 opcode.
- `req0_param`  in  16  port 0 parameter.
- `req0_ready`  out  1  one-cycle accept pulse to port 0.
- `req1_valid`, `req1_cmd`, `req1_param`, `req1_ready`: same as port 0, for port 1.
- `cpuline`  out  16  registered word to the GPU; 0 is NOP.
- `busy`  out  1  high while in CMD, PARAM or EXEC.
- `grant_id`  out  1  port that owns the current or most recent transaction.
- `err`  out  1  one-cycle pulse when a rejected opcode is dropped.

## Operation
- **Phase shadow `ph`.** `ph` is the GPU slot of the word currently on `cpuline`: A = command slot, B = parameter slot.
  - After reset, `ph` = A.
  - In IDLE, `ph` toggles every cycle.
  - In CMD, `ph` = A. In PARAM, `ph` = B.
  - In the first EXEC cycle, `ph` = A. It toggles on each further EXEC cycle.
- **States.**
  - IDLE: `cpuline` = 0.
  - CMD: `cpuline` = latched opcode.
  - PARAM: `cpuline` = latched param.
  - EXEC: `cpuline` = 0 for EXEC_GAP cycles, then return to IDLE.
- **Grant-eligible cycle.** A cycle is grant-eligible when the next cycle's `ph` will be A and the state is either IDLE or the last EXEC cycle.
- **Grant.** In a grant-eligible cycle with any valid request:
  - Arbitrate, assert the winner's `ready` for exactly that cycle, and latch its cmd/param.
  - Update `grant_id`.
  - Go to CMD on the next cycle.
  - If the eligible cycle is not the last EXEC cycle and no grant occurs, stay in IDLE.
- **Legal opcodes.** C1..C6, and C0 only with param == 0. Every other combination is rejected:
  - The request is granted and `ready` pulses as normal.
  - `err` pulses on the next cycle.
  - No CMD is issued; state and `cpuline` are unaffected, and `ph` keeps toggling.
  - Rejected grants still advance the round-robin pointer.
- **Requester rule.** A requester holds `valid`, `cmd` and `param` stable until it sees `ready`. Dropping `valid` early is legal; the request is then simply not granted.
- **Reset mid-operation.** `clr` aborts any transaction. The latched request is discarded, with no `ready` and no `err`.
- **Outputs during and after reset:** `cpuline` = 0, `req*_ready` = 0, `busy` = 0, `err` = 0, `grant_id` = 0, state = IDLE, `ph` = A, round-robin pointer = 1.

## Timing
- Grant at cycle t gives CMD at t+1, PARAM at t+2, and EXEC from t+3 to t+2+EXEC_GAP.
- The earliest next grant is at t+2+EXEC_GAP. With EXEC_GAP = 1, back-to-back throughput is one command per 3 cycles.
- First grant after reset: reset released at cycle 0 (`ph` A); cycle 1 is IDLE with `ph` B, so the first grant can occur at cycle 1 and its CMD at cycle 2.
- If a request arrives when the next slot would be B, it waits exactly 1 cycle.
- An even EXEC_GAP adds one extra IDLE cycle before the next CMD, so that CMD still lands in slot A.
- `busy` is registered and aligned with `cpuline`.
- `ready` and `err` are never asserted in the same cycle for the same request.

## Configuration
- `GPU_ARB_RR_EN` defined: round-robin arbitration.
  - When both ports are valid in the same cycle, the port not granted last wins.
  - The pointer resets to 1, so port 0 wins the first tie.
- `GPU_ARB_RR_EN` undefined: fixed priority.
  - Port 0 always wins a tie; port 1 is granted only when `req0_valid` = 0.
  - The round-robin pointer logic is removed.

## Test plan
- Reset, then port 0 requests {C1, 0x0041} in cycle 1 → `req0_ready` in cycle 1; `cpuline` = 0x00C1 in cycle 2, 0x0041 in cycle 3, 0 in cycle 4; `busy` high in cycles 2–4.
- Port 1 raises {C4, 5} in a cycle whose next `ph` is B → `ready` is delayed one cycle; 0x00C4 appears on `cpuline` only in an A slot, with param 0x0005 immediately after.
- Both ports hold valid continuously, each with 4 C1 commands → with RR, grants alternate 0,1,0,1… and `grant_id` tracks them; without the macro, all 4 port-0 commands go first. Consecutive CMDs are 3 cycles apart.
- Port 0 sends {C0, 1}, then {0x0012, 0} → each gets a `ready` pulse followed by an `err` pulse; `cpuline` stays 0 and `busy` stays 0.
- `clr` asserted during the PARAM cycle of {C3, 2} → the next cycle has `cpuline` = 0 and all outputs at reset values; a new request after release follows the first-grant timing.
- EXEC_GAP = 2, back-to-back C1 commands → the CMD spacing is 5 cycles, and every CMD falls in an A slot.

Source files
------------

// File: rtl/gpu_cmd_arbiter.sv
// rtl/gpu_cmd_arbiter.sv - two-port command sequencer/arbiter for the GPU cpuline bus
//
// Purpose:
//   Arbitrates between port 0 (CPU) and port 1 (boot/debug console) and
//   serialises each accepted request onto the 16-bit cpuline bus as a
//   CMD word, a PARAM word and EXEC_GAP zero words. A shadow of the GPU's
//   cmd/param slot phase (ph) makes every opcode word land in slot A.
//   Opcodes the GPU cannot execute are accepted (ready pulses) and then
//   dropped with a one-cycle err pulse.
//
// Parameters:
//   EXEC_GAP  zero-word cycles after PARAM before the next CMD (>= 1)
//
// Ports:
//   clk                  system clock, rising edge
//   clr                  synchronous active-high reset
//   req0_valid/cmd/param port 0 request; req0_ready is the accept pulse
//   req1_valid/cmd/param port 1 request; req1_ready is the accept pulse
//   cpuline              registered word to the GPU, 0 = NOP
//   busy                 high while cpuline carries CMD, PARAM or EXEC
//   grant_id             port owning the current or most recent grant
//   err                  one-cycle pulse after a rejected opcode is dropped
//
// Configuration:
//   GPU_ARB_RR_EN        defined: round-robin on ties; undefined: port 0 wins

module gpu_cmd_arbiter #(
  parameter int EXEC_GAP = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req0_valid,
  input  logic [15:0] req0_cmd,
  input  logic [15:0] req0_param,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_cmd,
  input  logic [15:0] req1_param,
  output logic        req1_ready,
  output logic [15:0] cpuline,
  output logic        busy,
  output logic        grant_id,
  output logic        err
);

  localparam int CW = (EXEC_GAP > 1) ? $clog2(EXEC_GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_PARAM,
    S_EXEC
  } state_t;

  state_t        state;
  logic          ph;          // slot of the word on cpuline: 0 = A, 1 = B
  logic          post_exec;   // previous cycle was the last EXEC cycle
  logic [CW-1:0] exec_cnt;
  logic [15:0]   lat_param;

  logic          last_exec;
  logic          eligible;
  logic          any_valid;
  logic          win;
  logic          grant;
  logic          legal;
  logic [15:0]   sel_cmd;
  logic [15:0]   sel_param;

`ifdef GPU_ARB_RR_EN
  logic          rr_last;     // port granted most recently

  always_ff @(posedge clk) begin
    if (clr) begin
      rr_last <= 1'b1;
    end else if (grant) begin
      rr_last <= win;
    end
  end
`endif

  assign last_exec = (state == S_EXEC) && (exec_cnt == CW'(EXEC_GAP - 1));

  // A new CMD must land in slot A. From IDLE that means the current slot
  // is B. At the end of EXEC the GPU is back at its command slot: with an
  // odd gap the last EXEC word already sits in A, with an even gap it sits
  // in B and the following IDLE cycle (slot A) is the grant point instead.
  assign eligible = ((state == S_IDLE) && (ph || post_exec)) ||
                    (last_exec && !ph);

  always_comb begin
    any_valid = req0_valid | req1_valid;
`ifdef GPU_ARB_RR_EN
    win = (req0_valid && req1_valid) ? ~rr_last : ~req0_valid;
`else
    win = ~req0_valid;
`endif
    grant     = eligible & any_valid & ~clr;
    sel_cmd   = win ? req1_cmd : req0_cmd;
    sel_param = win ? req1_param : req0_param;
    legal     = ((sel_cmd >= 16'h00C1) && (sel_cmd <= 16'h00C6)) ||
                ((sel_cmd == 16'h00C0) && (sel_param == 16'h0000));
  end

  assign req0_ready = grant & ~win;
  assign req1_ready = grant & win;

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      ph        <= 1'b0;
      post_exec <= 1'b0;
      exec_cnt  <= '0;
      lat_param <= 16'h0000;
      cpuline   <= 16'h0000;
      busy      <= 1'b0;
      grant_id  <= 1'b0;
      err       <= 1'b0;
    end else begin
      err       <= grant & ~legal;
      post_exec <= last_exec;
      if (grant) begin
        grant_id <= win;
      end
      case (state)
        S_CMD: begin
          state   <= S_PARAM;
          ph      <= 1'b1;
          cpuline <= lat_param;
          busy    <= 1'b1;
        end
        S_PARAM: begin
          state    <= S_EXEC;
          ph       <= 1'b0;
          exec_cnt <= '0;
          cpuline  <= 16'h0000;
          busy     <= 1'b1;
        end
        default: begin
          // IDLE or EXEC; a rejected grant falls through to the no-grant path
          if (grant && legal) begin
            state     <= S_CMD;
            ph        <= 1'b0;
            cpuline   <= sel_cmd;
            lat_param <= sel_param;
            busy      <= 1'b1;
          end else if ((state == S_EXEC) && !last_exec) begin
            exec_cnt <= exec_cnt + CW'(1);
            ph       <= ~ph;
            cpuline  <= 16'h0000;
            busy     <= 1'b1;
          end else begin
            state   <= S_IDLE;
            ph      <= ~ph;
            cpuline <= 16'h0000;
            busy    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_cmd_arbiter.sv
// tb/tb_gpu_cmd_arbiter.sv - self-checking bench for gpu_cmd_arbiter (EXEC_GAP 1 and 2)

module tb_gpu_cmd_arbiter;

  localparam int NC = 1024;
`ifdef GPU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        clr;
  logic        sel;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_cmd, req0_param, req1_cmd, req1_param;

  logic        clr_a, clr_b;
  logic        a_r0, a_r1, a_busy, a_gid, a_err;
  logic        b_r0, b_r1, b_busy, b_gid, b_err;
  logic [15:0] a_line, b_line;
  logic        o_r0, o_r1, o_busy, o_gid, o_err;
  logic [15:0] o_line_s;

  assign clr_a    = sel ? 1'b1 : clr;
  assign clr_b    = sel ? clr : 1'b1;
  assign o_r0     = sel ? b_r0 : a_r0;
  assign o_r1     = sel ? b_r1 : a_r1;
  assign o_busy   = sel ? b_busy : a_busy;
  assign o_gid    = sel ? b_gid : a_gid;
  assign o_err    = sel ? b_err : a_err;
  assign o_line_s = sel ? b_line : a_line;

  gpu_cmd_arbiter #(.EXEC_GAP(1)) u_gap1 (
    .clk(clk), .clr(clr_a),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_param(req0_param), .req0_ready(a_r0),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_param(req1_param), .req1_ready(a_r1),
    .cpuline(a_line), .busy(a_busy), .grant_id(a_gid), .err(a_err)
  );

  gpu_cmd_arbiter #(.EXEC_GAP(2)) u_gap2 (
    .clk(clk), .clr(clr_b),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_param(req0_param), .req0_ready(b_r0),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_param(req1_param), .req1_ready(b_r1),
    .cpuline(b_line), .busy(b_busy), .grant_id(b_gid), .err(b_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: expected word/busy/err per cycle, plus the set of
  // cycles in which a grant may happen: {e0} U {e1, e1+2, e1+4, ...}
  int          n;
  int          gap;
  int          e0, e1;
  bit          rr_last;
  logic        gid;
  logic [15:0] x_line [NC];
  bit          x_busy [NC];
  bit          x_err  [NC];
  logic [15:0] o_line [NC];
  logic        o_busyv[NC];
  logic        o_errv [NC];
  logic [31:0] rq0[$];
  logic [31:0] rq1[$];
  int          gq_n[$];
  int          gq_w[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (gap=%0d cycle=%0d): got %h expected %h", tag, gap, n, obs, exp);
    end
  endtask

  function automatic bit elig(input int c);
    return (c == e0) || ((c >= e1) && (((c - e1) % 2) == 0));
  endfunction

  function automatic logic [31:0] rand_req();
    int r;
    logic [15:0] c, p;
    r = $urandom_range(0, 8);
    p = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
    if (r == 0)      c = 16'h00C0;
    else if (r <= 6) c = 16'h00C0 + 16'(r);
    else if (r == 7) c = 16'($urandom);
    else             c = 16'h00C7;
    return {c, p};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NC; i++) begin
      x_line[i] = 16'h0; x_busy[i] = 1'b0; x_err[i] = 1'b0;
      o_line[i] = 16'h0; o_busyv[i] = 1'b0; o_errv[i] = 1'b0;
    end
    n = 0; e0 = -1; e1 = 2; rr_last = 1'b1; gid = 1'b0;
    rq0.delete(); rq1.delete(); gq_n.delete(); gq_w.delete();
  endtask

  task automatic step(input bit c);
    bit e, g, w, lg;
    logic [15:0] gc, gp;
    @(posedge clk);
    #1;
    clr        = c;
    req0_valid = (rq0.size() != 0);
    req0_cmd   = req0_valid ? rq0[0][31:16] : 16'h0;
    req0_param = req0_valid ? rq0[0][15:0] : 16'h0;
    req1_valid = (rq1.size() != 0);
    req1_cmd   = req1_valid ? rq1[0][31:16] : 16'h0;
    req1_param = req1_valid ? rq1[0][15:0] : 16'h0;
    @(negedge clk);
    e = !c && elig(n);
    g = e && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) w = RR ? !rr_last : 1'b0;
    else                          w = !req0_valid;
    chk("req0_ready", o_r0, g && !w);
    chk("req1_ready", o_r1, g && w);
    chk("cpuline", o_line_s, x_line[n]);
    chk("busy", o_busy, x_busy[n]);
    chk("err", o_err, x_err[n]);
    chk("grant_id", o_gid, gid);
    o_line[n] = o_line_s; o_busyv[n] = o_busy; o_errv[n] = o_err;
    if (c) begin
      for (int i = n + 1; i < NC; i++) begin
        x_line[i] = 16'h0; x_busy[i] = 1'b0; x_err[i] = 1'b0;
      end
      e0 = -1; e1 = n + 2; rr_last = 1'b1; gid = 1'b0;
    end else if (g) begin
      gc = w ? req1_cmd : req0_cmd;
      gp = w ? req1_param : req0_param;
      lg = ((gc >= 16'h00C1) && (gc <= 16'h00C6)) || ((gc == 16'h00C0) && (gp == 16'h0));
      rr_last = w; gid = w;
      gq_n.push_back(n); gq_w.push_back(int'(w));
      if (w) void'(rq1.pop_front()); else void'(rq0.pop_front());
      if (lg) begin
        x_line[n + 1] = gc;
        x_line[n + 2] = gp;
        for (int k = 1; k <= 2 + gap; k++) x_busy[n + k] = 1'b1;
        e0 = n + 2 + gap + (((gap % 2) == 0) ? 1 : 0);
        e1 = e0 + 1;
      end else begin
        x_err[n + 1] = 1'b1;
      end
    end
    n++;
  endtask

  initial begin
    int base, raise, g, start, guard, ecount, bcount, sp;
    clk = 1'b0; clr = 1'b1; sel = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_cmd = 16'h0; req0_param = 16'h0; req1_cmd = 16'h0; req1_param = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      gap = (d == 0) ? 1 : 2;
      sp  = (d == 0) ? 3 : 5;
      model_clear();

      // reset, then first grant timing with {C1, 0x0041}
      step(1'b1);
      rq0.push_back({16'h00C1, 16'h0041});
      for (int i = 0; i < 5 + gap; i++) step(1'b0);
      chk("first_grant_cycle", 16'(gq_n.size() > 0 ? gq_n[0] : -1), 16'd2);
      chk("first_cmd", o_line[3], 16'h00C1);
      chk("first_param", o_line[4], 16'h0041);
      chk("first_exec", o_line[5], 16'h0000);
      chk("first_busy_cmd", o_busyv[3], 1'b1);
      chk("first_busy_exec", o_busyv[4 + gap], 1'b1);
      chk("first_busy_off", o_busyv[5 + gap], 1'b0);

      // port 1 request raised when the next slot is B waits one cycle
      guard = 0;
      while (!((n > e1) && !elig(n)) && guard < 10) begin step(1'b0); guard++; end
      raise = n;
      base  = gq_n.size();
      rq1.push_back({16'h00C4, 16'h0005});
      for (int i = 0; i < 5; i++) step(1'b0);
      chk("b_slot_grants", 16'(gq_n.size() - base), 16'd1);
      if (gq_n.size() > base) begin
        chk("b_slot_delay", 16'(gq_n[base] - raise), 16'd1);
        chk("b_slot_port", 16'(gq_w[base]), 16'd1);
      end
      chk("b_slot_cmd", o_line[raise + 2], 16'h00C4);
      chk("b_slot_param", o_line[raise + 3], 16'h0005);

      // both ports continuously valid, 4 C1 commands each
      base = gq_n.size();
      for (int i = 0; i < 4; i++) begin
        rq0.push_back({16'h00C1, 16'(16'h0010 + i)});
        rq1.push_back({16'h00C1, 16'(16'h0020 + i)});
      end
      guard = 0;
      while ((rq0.size() != 0 || rq1.size() != 0) && guard < 100) begin step(1'b0); guard++; end
      chk("tie_grants", 16'(gq_n.size() - base), 16'd8);
      if (gq_n.size() >= base + 8) begin
        for (int k = 0; k < 8; k++) begin
          chk("tie_order", 16'(gq_w[base + k]), RR ? 16'(k % 2) : 16'(k >= 4));
          if (k > 0) chk("tie_spacing", 16'(gq_n[base + k] - gq_n[base + k - 1]), 16'(sp));
        end
      end
      for (int i = 0; i < 6; i++) step(1'b0);

      // rejected opcodes: ready then err, nothing on the bus
      start = n;
      rq0.push_back({16'h00C0, 16'h0001});
      rq0.push_back({16'h0012, 16'h0000});
      guard = 0;
      while (rq0.size() != 0 && guard < 20) begin step(1'b0); guard++; end
      for (int i = 0; i < 3; i++) step(1'b0);
      ecount = 0; bcount = 0;
      for (int i = start; i < n; i++) begin
        ecount += int'(o_errv[i] === 1'b1);
        bcount += int'(o_busyv[i] !== 1'b0) + int'(o_line[i] !== 16'h0);
      end
      chk("reject_err_pulses", 16'(ecount), 16'd2);
      chk("reject_bus_quiet", 16'(bcount), 16'd0);

      // clr during PARAM of {C3, 2}, then first-grant timing again
      base = gq_n.size();
      rq0.push_back({16'h00C3, 16'h0002});
      guard = 0;
      while (gq_n.size() == base && guard < 10) begin step(1'b0); guard++; end
      g = n - 1;
      step(1'b0);
      step(1'b1);
      rq0.push_back({16'h00C2, 16'h0007});
      for (int i = 0; i < 4; i++) step(1'b0);
      chk("clr_line", o_line[g + 3], 16'h0000);
      chk("clr_busy", o_busyv[g + 3], 1'b0);
      chk("clr_regrant", 16'(gq_n.size() == base + 2 ? gq_n[base + 1] - g : -1), 16'd4);
      chk("clr_new_cmd", o_line[g + 5], 16'h00C2);

      // randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
        if (rq0.size() == 0 && $urandom_range(0, 2) == 0) rq0.push_back(rand_req());
        if (rq1.size() == 0 && $urandom_range(0, 2) == 0) rq1.push_back(rand_req());
        step($urandom_range(0, 99) == 0);
      end
      rq0.delete(); rq1.delete();
      for (int i = 0; i < 8; i++) step(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
